// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default geometry for the parametrised FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port storage: synchronous write port, synchronous registered read port.
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        re,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array left unreset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, threshold flags and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_signal,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        read_signal,
  output logic [WIDTH-1:0]            data_out,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  // A read accepted while full frees a slot, so a concurrent write is also taken.
  assign rd_acc = read_signal & ~empty;
  assign wr_acc = write_signal & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    // A new error outranks a same-cycle clear.
    overflow_d  = (write_signal & ~wr_acc) | (overflow_q & ~clr_err);
    underflow_d = (read_signal & ~rd_acc) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with a queue-based reference model checked every cycle.
module tb_sync_fifo_param;

  localparam int unsigned W   = 8;
  localparam int unsigned D   = 8;
  localparam int unsigned AFT = 6;
  localparam int unsigned AET = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write_signal = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         read_signal = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] data_out;
  logic         rd_valid, full, empty, almost_full, almost_empty;
  logic [3:0]   count;
  logic         overflow, underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sync_fifo_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AFT),
    .AE_THRESH (AET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_signal (write_signal),
    .data_in      (data_in),
    .read_signal  (read_signal),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, outputs derived from its size.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit           m_valid = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  always @(posedge clk) begin
    bit racc, wacc;
    if (rst) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      racc = read_signal && (q.size() > 0);
      wacc = write_signal && ((q.size() < D) || racc);
      if (racc) m_dout = q.pop_front();
      m_valid = racc;
      if (wacc) q.push_back(data_in);
      m_ovf = (write_signal && !wacc) || (m_ovf && !clr_err);
      m_unf = (read_signal && !racc) || (m_unf && !clr_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.count", 32'(count), 32'(q.size()));
      chk("m.empty", 32'(empty), 32'(q.size() == 0));
      chk("m.full", 32'(full), 32'(q.size() == D));
      chk("m.almost_full", 32'(almost_full), 32'(q.size() >= AFT));
      chk("m.almost_empty", 32'(almost_empty), 32'(q.size() <= AET));
      chk("m.rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("m.data_out", 32'(data_out), 32'(m_dout));
      chk("m.overflow", 32'(overflow), 32'(m_ovf));
      chk("m.underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // Apply one cycle of requests; returns just after the edge that consumes them.
  task automatic step(input bit wr, input logic [W-1:0] din, input bit rd,
                      input bit clr = 1'b0, input bit r = 1'b0);
    write_signal = wr;
    data_in      = din;
    read_signal  = rd;
    clr_err      = clr;
    rst          = r;
    @(posedge clk);
    #1;
    write_signal = 1'b0;
    read_signal  = 1'b0;
    clr_err      = 1'b0;
    rst          = 1'b0;
  endtask

  initial begin
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Reset then idle
    step(1'b0, '0, 1'b0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.data_out", 32'(data_out), 32'd0);
    chk("rst.almost_empty", 32'(almost_empty), 32'd1);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill.count", 32'(count), 32'(i));
      chk("fill.almost_full", 32'(almost_full), 32'(i >= 6));
    end
    chk("fill.full", 32'(full), 32'd1);
    step(1'b1, 8'h09, 1'b0);
    chk("ovf.overflow", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain.data_out", 32'(data_out), 32'(i));
      chk("drain.rd_valid", 32'(rd_valid), 32'd1);
    end
    chk("drain.empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("unf.underflow", 32'(underflow), 32'd1);
    chk("unf.rd_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr.overflow", 32'(overflow), 32'd0);
    chk("clr.underflow", 32'(underflow), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("clrset.underflow", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read+write while full
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    chk("fullrw.data_out", 32'(data_out), 32'h01);
    chk("fullrw.count", 32'(count), 32'd8);
    chk("fullrw.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("fullrw.last", 32'(data_out), 32'hAA);
    chk("fullrw.empty", 32'(empty), 32'd1);

    // Simultaneous read+write while empty
    step(1'b1, 8'h55, 1'b1);
    chk("emptyrw.underflow", 32'(underflow), 32'd1);
    chk("emptyrw.count", 32'(count), 32'd1);
    chk("emptyrw.rd_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("emptyrw.data_out", 32'(data_out), 32'h55);

    // Interleaved traffic across the pointer wrap
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0);
      step(1'b0, '0, 1'b1);
      chk("wrap.data_out", 32'(data_out), 32'(8'h20 + i));
    end
    step(1'b0, '0, 1'b0, 1'b1);
    chk("wrap.clr_underflow", 32'(underflow), 32'd0);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    chk("midrst.count5", 32'(count), 32'd5);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst.data_out", 32'(data_out), 32'd0);
    step(1'b0, '0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
